// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: decodes fetched instructions, reads the register file,
// resolves operands through EX/MEM forwarding and holds the ID/EX pipeline register.
module operand_fetch #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter bit          FWD_EN      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  output logic                   if_ready,
  output logic                   re1,
  output logic [4:0]             raddr1,
  output logic                   re2,
  output logic [4:0]             raddr2,
  input  logic [31:0]            rdata1,
  input  logic [31:0]            rdata2,
  input  logic                   ex_we,
  input  logic [4:0]             ex_waddr,
  input  logic [31:0]            ex_wdata,
  input  logic                   mem_we,
  input  logic [4:0]             mem_waddr,
  input  logic [31:0]            mem_wdata,
  input  logic                   ex_ready,
  output logic                   id_valid,
  output logic [5:0]             id_opcode,
  output logic [5:0]             id_funct,
  output logic [31:0]            id_op1,
  output logic [31:0]            id_op2,
  output logic [31:0]            id_store_data,
  output logic                   id_wreg,
  output logic [4:0]             id_waddr,
  output logic                   id_is_load,
  output logic                   id_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {OP1_ZERO, OP1_REG, OP1_SHAMT} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_REG, OP2_IMM}   op2_sel_e;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [15:0] imm_s;
  logic        dec_re1_s, dec_re2_s, dec_wreq_s, dec_load_s, dec_store_s, dec_illegal_s;
  logic [4:0]  dec_dest_s;
  logic [5:0]  dec_funct_s;
  logic [31:0] ext_imm_s;
  op1_sel_e    op1_sel_s;
  op2_sel_e    op2_sel_s;
  logic        dec_wreg_s;
  logic [4:0]  dec_waddr_s;
  logic [31:0] src1_s, src2_s, op1_s, op2_s, store_s;
  logic        load_hazard_s, nofwd_hazard_s, hazard_s, advance_s;

  function automatic logic legal_funct(input logic [5:0] f);
    case (f)
      6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Register address 0 never matches a writer; only enabled reads can match.
  function automatic logic addr_hit(input logic re, input logic [4:0] raddr,
                                    input logic we, input logic [4:0] waddr);
    return re && we && (waddr != 5'd0) && (raddr == waddr);
  endfunction

  function automatic logic [31:0] fwd_operand(input logic re, input logic [4:0] addr,
                                              input logic [31:0] rf);
    if (!re || addr == 5'd0)                         return 32'd0;
    else if (FWD_EN && ex_we && ex_waddr == addr)    return ex_wdata;
    else if (FWD_EN && mem_we && mem_waddr == addr)  return mem_wdata;
    else                                             return rf;
  endfunction

  assign opcode_s = if_inst[31:26];
  assign rs_s     = if_inst[25:21];
  assign rt_s     = if_inst[20:16];
  assign rd_s     = if_inst[15:11];
  assign shamt_s  = if_inst[10:6];
  assign funct_s  = if_inst[5:0];
  assign imm_s    = if_inst[15:0];

  // Instruction decode: read ports, destination and operand source selects.
  always_comb begin
    dec_re1_s     = 1'b0;
    dec_re2_s     = 1'b0;
    dec_wreq_s    = 1'b0;
    dec_dest_s    = 5'd0;
    dec_load_s    = 1'b0;
    dec_store_s   = 1'b0;
    dec_illegal_s = 1'b0;
    dec_funct_s   = 6'd0;
    ext_imm_s     = 32'd0;
    op1_sel_s     = OP1_ZERO;
    op2_sel_s     = OP2_ZERO;
    case (opcode_s)
      OP_RTYPE: begin
        dec_funct_s = funct_s;
        if (legal_funct(funct_s)) begin
          dec_re2_s  = 1'b1;
          dec_wreq_s = 1'b1;
          dec_dest_s = rd_s;
          op2_sel_s  = OP2_REG;
          if (funct_s == 6'h00 || funct_s == 6'h02 || funct_s == 6'h03) begin
            dec_re1_s = 1'b0;
            op1_sel_s = OP1_SHAMT;
          end else begin
            dec_re1_s = 1'b1;
            op1_sel_s = OP1_REG;
          end
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_re1_s   = 1'b1;
        op1_sel_s   = OP1_REG;
        op2_sel_s   = OP2_IMM;
        ext_imm_s   = {{16{imm_s[15]}}, imm_s};
        dec_load_s  = (opcode_s == OP_LW);
        dec_store_s = (opcode_s == OP_SW);
        dec_re2_s   = (opcode_s == OP_SW);
        dec_wreq_s  = (opcode_s != OP_SW);
        dec_dest_s  = rt_s;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_re1_s  = 1'b1;
        op1_sel_s  = OP1_REG;
        op2_sel_s  = OP2_IMM;
        ext_imm_s  = {16'd0, imm_s};
        dec_wreq_s = 1'b1;
        dec_dest_s = rt_s;
      end
      OP_LUI: begin
        op2_sel_s  = OP2_IMM;
        ext_imm_s  = {imm_s, 16'd0};
        dec_wreq_s = 1'b1;
        dec_dest_s = rt_s;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // A destination of r0 is not a register write; its address is reported as 0.
  assign dec_wreg_s  = dec_wreq_s && (dec_dest_s != 5'd0);
  assign dec_waddr_s = dec_wreg_s ? dec_dest_s : 5'd0;

  assign re1    = if_valid & dec_re1_s;
  assign re2    = if_valid & dec_re2_s;
  assign raddr1 = re1 ? rs_s : 5'd0;
  assign raddr2 = re2 ? rt_s : 5'd0;

  assign src1_s = fwd_operand(re1, raddr1, rdata1);
  assign src2_s = fwd_operand(re2, raddr2, rdata2);

  // Operand assembly from the resolved register values and the immediate.
  always_comb begin
    op1_s   = 32'd0;
    op2_s   = 32'd0;
    store_s = 32'd0;
    case (op1_sel_s)
      OP1_REG:   op1_s = src1_s;
      OP1_SHAMT: op1_s = {27'd0, shamt_s};
      default:   op1_s = 32'd0;
    endcase
    case (op2_sel_s)
      OP2_REG: op2_s = src2_s;
      OP2_IMM: op2_s = ext_imm_s;
      default: op2_s = 32'd0;
    endcase
    if (dec_store_s) begin
      store_s = src2_s;
    end else begin
      store_s = 32'd0;
    end
  end

  // Without forwarding every in-flight writer of a source register must drain first.
  assign load_hazard_s  = id_valid && id_is_load &&
                          (addr_hit(re1, raddr1, 1'b1, id_waddr) || addr_hit(re2, raddr2, 1'b1, id_waddr));
  assign nofwd_hazard_s = !FWD_EN &&
                          (addr_hit(re1, raddr1, ex_we, ex_waddr)   || addr_hit(re2, raddr2, ex_we, ex_waddr)   ||
                           addr_hit(re1, raddr1, mem_we, mem_waddr) || addr_hit(re2, raddr2, mem_we, mem_waddr) ||
                           addr_hit(re1, raddr1, id_valid && id_wreg, id_waddr) ||
                           addr_hit(re2, raddr2, id_valid && id_wreg, id_waddr));
  assign hazard_s  = load_hazard_s || nofwd_hazard_s;
  assign advance_s = !id_valid || ex_ready;
  assign if_ready  = rst_n && advance_s && !hazard_s;

  // ID/EX pipeline register and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid      <= 1'b0;
      id_opcode     <= 6'd0;
      id_funct      <= 6'd0;
      id_op1        <= 32'd0;
      id_op2        <= 32'd0;
      id_store_data <= 32'd0;
      id_wreg       <= 1'b0;
      id_waddr      <= 5'd0;
      id_is_load    <= 1'b0;
      id_illegal    <= 1'b0;
      stall_cnt     <= {STALL_CNT_W{1'b0}};
    end else if (advance_s) begin
      if (hazard_s) begin
        id_valid <= 1'b0;
        if (stall_cnt != {STALL_CNT_W{1'b1}}) begin
          stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        id_valid <= if_valid;
        if (if_valid) begin
          id_opcode     <= opcode_s;
          id_funct      <= dec_funct_s;
          id_op1        <= op1_s;
          id_op2        <= op2_s;
          id_store_data <= store_s;
          id_wreg       <= dec_wreg_s;
          id_waddr      <= dec_waddr_s;
          id_is_load    <= dec_load_s;
          id_illegal    <= dec_illegal_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed instructions push expected ID/EX contents,
// a negedge monitor compares whatever the DUT presents on id_*.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, mem_we, ex_ready;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic        id_valid, id_wreg, id_is_load, id_illegal;
  logic [5:0]  id_opcode, id_funct;
  logic [31:0] id_op1, id_op2, id_store_data;
  logic [4:0]  id_waddr;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic        wreg;
    logic [4:0]  waddr;
    logic        load;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
  } fwd_t;

  exp_t sb[$];

  operand_fetch #(.STALL_CNT_W(16), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct), .id_op1(id_op1),
    .id_op2(id_op2), .id_store_data(id_store_data), .id_wreg(id_wreg), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .id_illegal(id_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic exp_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [31:0] sd, input logic wr,
                              input logic [4:0] wa, input logic ld, input logic il);
    exp_t e;
    e.opcode = op; e.funct = fn; e.op1 = o1; e.op2 = o2; e.sd = sd;
    e.wreg = wr; e.waddr = wa; e.load = ld; e.illegal = il;
    return e;
  endfunction

  function automatic fwd_t mkf(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                               input logic mw, input logic [4:0] ma, input logic [31:0] md);
    fwd_t f;
    f.ex_we = ew; f.ex_waddr = ea; f.ex_wdata = ed;
    f.mem_we = mw; f.mem_waddr = ma; f.mem_wdata = md;
    return f;
  endfunction

  // Drive one cycle of stimulus just after the edge, then check if_ready mid-cycle.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] rd1,
                      input logic [31:0] rd2, input fwd_t f, input logic exr,
                      input logic exp_rdy, input logic push, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    if_valid  = v;        if_inst   = inst;
    rdata1    = rd1;      rdata2    = rd2;
    ex_we     = f.ex_we;  ex_waddr  = f.ex_waddr;  ex_wdata  = f.ex_wdata;
    mem_we    = f.mem_we; mem_waddr = f.mem_waddr; mem_wdata = f.mem_wdata;
    ex_ready  = exr;
    if (push) sb.push_back(e);
    @(negedge clk);
    chk({tag, " if_ready"}, 32'(if_ready), 32'(exp_rdy));
  endtask

  // Monitor: compare the head of the scoreboard; pop only when EX consumes it.
  always @(negedge clk) begin
    if (rst_n && id_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got id_opcode %h with no expected entry", id_opcode);
      end else begin
        chk("sb opcode",  32'(id_opcode),  32'(sb[0].opcode));
        chk("sb funct",   32'(id_funct),   32'(sb[0].funct));
        chk("sb op1",     id_op1,          sb[0].op1);
        chk("sb op2",     id_op2,          sb[0].op2);
        chk("sb store",   id_store_data,   sb[0].sd);
        chk("sb wreg",    32'(id_wreg),    32'(sb[0].wreg));
        chk("sb waddr",   32'(id_waddr),   32'(sb[0].waddr));
        chk("sb is_load", 32'(id_is_load), 32'(sb[0].load));
        chk("sb illegal", 32'(id_illegal), 32'(sb[0].illegal));
        if (ex_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fwd_t nf;
    exp_t ne;
    nf = '0;
    ne = '0;
    rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'd0; rdata1 = 32'd0; rdata2 = 32'd0;
    ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0; ex_ready = 1'b1;
    repeat (3) @(negedge clk);
    if_valid = 1'b1;
    #1;
    chk("rst if_ready", 32'(if_ready), 32'd0);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    if_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst if_ready", 32'(if_ready), 32'd1);
    chk("post-rst id_valid", 32'(id_valid), 32'd0);
    chk("post-rst stall_cnt", 32'(stall_cnt), 32'd0);

    // ADDI r2,r1,-1
    step(1'b1, enc_i(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h08, 6'h00, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd2, 1'b0, 1'b0), "addi");
    chk("addi re1", 32'(re1), 32'd1);
    chk("addi raddr1", 32'(raddr1), 32'd1);
    chk("addi re2", 32'(re2), 32'd0);
    // ADD r3,r1,r2 : EX beats MEM beats regfile
    step(1'b1, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'hC, 32'd7,
         mkf(1'b1, 5'd1, 32'hA, 1'b1, 5'd1, 32'hB), 1'b1, 1'b1, 1'b1,
         mk(6'h00, 6'h20, 32'hA, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0, 1'b0), "add_fwd");
    chk("add re2", 32'(re2), 32'd1);
    chk("add raddr2", 32'(raddr2), 32'd2);
    // ORI r6,r2,0x8001 : MEM forward, non-matching EX
    step(1'b1, enc_i(6'h0D, 5'd2, 5'd6, 16'h8001), 32'h99, 32'd0,
         mkf(1'b1, 5'd9, 32'hEE, 1'b1, 5'd2, 32'h55), 1'b1, 1'b1, 1'b1,
         mk(6'h0D, 6'h00, 32'h55, 32'h0000_8001, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0), "ori");
    // SLL r7,r3,4
    step(1'b1, enc_r(5'd0, 5'd3, 5'd7, 5'd4, 6'h00), 32'h33, 32'h10, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h00, 6'h00, 32'd4, 32'h10, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0), "sll");
    chk("sll re1", 32'(re1), 32'd0);
    // LUI r8,0x1234
    step(1'b1, enc_i(6'h0F, 5'd0, 5'd8, 16'h1234), 32'd0, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h0F, 6'h00, 32'd0, 32'h1234_0000, 32'd0, 1'b1, 5'd8, 1'b0, 1'b0), "lui");
    // LW r4,-4(r1) then ADD r5,r4,r4 : one bubble
    step(1'b1, enc_i(6'h23, 5'd1, 5'd4, 16'hFFFC), 32'h100, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h23, 6'h00, 32'h100, 32'hFFFF_FFFC, 32'd0, 1'b1, 5'd4, 1'b1, 1'b0), "lw");
    step(1'b1, enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'h20), 32'd0, 32'd0, nf, 1'b1, 1'b0, 1'b0, ne, "lu_stall");
    chk("lu_stall stall_cnt", 32'(stall_cnt), 32'd0);
    step(1'b1, enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'h20), 32'd0, 32'd0,
         mkf(1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'd0), 1'b1, 1'b1, 1'b1,
         mk(6'h00, 6'h20, 32'h1234, 32'h1234, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0), "lu_retry");
    chk("bubble id_valid", 32'(id_valid), 32'd0);
    chk("bubble stall_cnt", 32'(stall_cnt), 32'd1);
    // SW r9,8(r2), then hold it with ex_ready=0 while XORI waits
    step(1'b1, enc_i(6'h2B, 5'd2, 5'd9, 16'h0008), 32'h200, 32'hCAFE, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h2B, 6'h00, 32'h200, 32'd8, 32'hCAFE, 1'b0, 5'd0, 1'b0, 1'b0), "sw");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, enc_i(6'h0E, 5'd1, 5'd10, 16'hF0F0), 32'h0F0F, 32'd0, nf, 1'b0, 1'b0, 1'b0, ne, "hold");
    end
    step(1'b1, enc_i(6'h0E, 5'd1, 5'd10, 16'hF0F0), 32'h0F0F, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h0E, 6'h00, 32'h0F0F, 32'h0000_F0F0, 32'd0, 1'b1, 5'd10, 1'b0, 1'b0), "xori");
    // Illegal opcode 3F
    step(1'b1, enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd1, 32'd2, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h3F, 6'h00, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1), "illegal");
    chk("illegal re1", 32'(re1), 32'd0);
    chk("illegal re2", 32'(re2), 32'd0);
    // ADD r11,r0,r0 with writers reporting address 0
    step(1'b1, enc_r(5'd0, 5'd0, 5'd11, 5'd0, 6'h20), 32'h77, 32'h77,
         mkf(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF), 1'b1, 1'b1, 1'b1,
         mk(6'h00, 6'h20, 32'd0, 32'd0, 32'd0, 1'b1, 5'd11, 1'b0, 1'b0), "r0_read");
    // ADDI r0,r1,5 : no register write
    step(1'b1, enc_i(6'h08, 5'd1, 5'd0, 16'h0005), 32'h40, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h08, 6'h00, 32'h40, 32'd5, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0), "addi_r0");
    // LW r0 followed by a reader of r0 : no hazard
    step(1'b1, enc_i(6'h23, 5'd1, 5'd0, 16'h0000), 32'h80, 32'd0, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h23, 6'h00, 32'h80, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0), "lw_r0");
    step(1'b1, enc_r(5'd0, 5'd1, 5'd12, 5'd0, 6'h20), 32'd0, 32'h31, nf, 1'b1, 1'b1, 1'b1,
         mk(6'h00, 6'h20, 32'd0, 32'h31, 32'd0, 1'b1, 5'd12, 1'b0, 1'b0), "use_r0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, nf, 1'b1, 1'b1, 1'b0, ne, "drain");
    end
    chk("final sb empty", 32'(sb.size()), 32'd0);
    chk("final stall_cnt", 32'(stall_cnt), 32'd1);
    chk("final id_valid", 32'(id_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-stage reader for the 2-read/1-write register file.
- Takes fetched instructions over a valid/ready handshake, decodes register fields, drives regfile read ports (re1/raddr1, re2/raddr2), and resolves operands through EX/MEM forwarding.
- Holds the ID/EX pipeline register and detects load-use hazards, inserting bubbles and stalling fetch.

Parameters:
- STALL_CNT_W, 16, width of saturating load-use stall counter
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only (hazard stall then also covers EX/MEM writers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents instruction
- if_inst  in  32  instruction word
- if_ready  out  1  decode accepts instruction (combinational)
- re1  out  1  regfile read enable port 1
- raddr1  out  5  read address port 1 (rs)
- re2  out  1  regfile read enable port 2
- raddr2  out  5  read address port 2 (rt)
- rdata1  in  32  regfile data port 1, same cycle, WB bypass already applied
- rdata2  in  32  regfile data port 2
- ex_we  in  1  EX-stage result writes a register
- ex_waddr  in  5  EX destination
- ex_wdata  in  32  EX result
- mem_we  in  1  MEM-stage writes a register
- mem_waddr  in  5  MEM destination
- mem_wdata  in  32  MEM result
- ex_ready  in  1  EX accepts ID/EX contents
- id_valid  out  1  ID/EX register holds an instruction
- id_opcode  out  6  opcode
- id_funct  out  6  funct (0 for I-type)
- id_op1  out  32  ALU operand 1
- id_op2  out  32  ALU operand 2
- id_store_data  out  32  rt value for SW, else 0
- id_wreg  out  1  instruction writes a register
- id_waddr  out  5  destination register
- id_is_load  out  1  instruction is LW
- id_illegal  out  1  unsupported opcode/funct
- stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, async): id_valid=0, stall_cnt=0, all id_* fields=0. Mid-operation reset drops the held instruction. No fetch is accepted while rst_n=0 (if_ready=0).
- Decode, combinational from if_inst, gated by if_valid:
  - R-type (op 0): re1=rs, re2=rt, wreg rd; op1=rs, op2=rt.
  - SLL/SRL/SRA (funct 00/02/03): re1=0; op1={27'b0,shamt}.
  - ADDI 08: sign-extended immediate.
  - ANDI 0C, ORI 0D, XORI 0E: zero-extended immediate.
  - All three I-type groups above: re1=rs, wreg rt, op2=imm.
  - LUI 0F: re1=0, op1=0, op2={imm,16'b0}, wreg rt.
  - LW 23: re1=rs, op2=sext, wreg rt, is_load=1.
  - SW 2B: re1=rs, re2=rt, op2=sext, store_data=rt, wreg=0.
  - Other: id_illegal=1, no reads, wreg=0.
  - Destination r0 forces id_wreg=0.
- Operand select per port:
  - Address 0 or re=0 -> 0.
  - Else EX match (ex_we, ex_waddr==addr) -> ex_wdata.
  - Else MEM match -> mem_wdata.
  - Else rdata. EX has priority over MEM.
- Hazard: id_valid && id_is_load && id_waddr!=0 && an enabled read port matches id_waddr.
- advance = !id_valid || ex_ready.
- if_ready = advance && !hazard.
- On each clk:
  - If advance && hazard: load bubble (id_valid=0) and increment stall_cnt, saturating at all-ones.
  - If advance && !hazard: id_valid=if_valid and capture fields when if_valid.
  - If !advance: hold all id_* stable.
- Latency: accepted instruction appears on id_* the next cycle. One bubble per load-use; the second attempt forwards from EX/MEM normally.

Test Plan:
- Reset held, then released with if_valid=0 -> id_valid=0, stall_cnt=0, if_ready=1.
- ADDI r2,r1,-1 with rdata1=5 -> next cycle id_op1=5, id_op2=FFFFFFFF, id_waddr=2, id_wreg=1.
- ADD r3,r1,r2 with ex_we, ex_waddr=1, ex_wdata=A, mem_we, mem_waddr=1, mem_wdata=B, rdata1=C, rdata2=7 -> id_op1=A, id_op2=7.
- LW r4,0(r1) then ADD r5,r4,r4 -> one cycle if_ready=0, id_valid=0, stall_cnt=1; ADD then issues.
- ex_ready=0 with id_valid=1 -> all id_* stable, if_ready=0; released -> next instruction captured.
- Opcode 3F -> id_illegal=1, re1=re2=0, id_wreg=0; reads of r0 -> operand 0 despite ex_waddr=0 match.
